// File: rtl/fadd_result_collector_if.sv
// Bundle of the collector's three bus groups: core request side, fadd
// operand/result side, and in-order response side plus the overflow flag.
// The collector uses the slave view; the environment around it uses master.
interface fadd_result_collector_if #(
    parameter int TAG_W = 4
);
    // Both handshakes are strict valid/ready: a transfer happens on a rising
    // clock edge where valid and ready are both high; valid must not depend
    // on ready, and the payload is only meaningful while valid is high.
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_s;
    logic [31:0]      req_t;
    logic             req_sub;
    logic [TAG_W-1:0] req_tag;

    logic [31:0]      fadd_s;
    logic [31:0]      fadd_t;
    logic [31:0]      fadd_d;
    logic             fadd_overflow;

    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_d;
    logic             resp_overflow;
    logic [TAG_W-1:0] resp_tag;

    logic             ovf_sticky;
    logic             ovf_clr;

    modport slave (
        input  req_valid, req_s, req_t, req_sub, req_tag,
        output req_ready,
        output fadd_s, fadd_t,
        input  fadd_d, fadd_overflow,
        output resp_valid, resp_d, resp_overflow, resp_tag,
        input  resp_ready,
        output ovf_sticky,
        input  ovf_clr
    );

    modport master (
        output req_valid, req_s, req_t, req_sub, req_tag,
        input  req_ready,
        input  fadd_s, fadd_t,
        output fadd_d, fadd_overflow,
        input  resp_valid, resp_d, resp_overflow, resp_tag,
        output resp_ready,
        input  ovf_sticky,
        output ovf_clr
    );
endinterface

// File: rtl/fadd_result_collector.sv
// Issue/return front end for the non-stallable pipelined fadd unit.
// Requests are forwarded straight to fadd's operands; a {valid, tag} shift
// register follows each accepted op through fadd, and the matching result is
// captured into a small FIFO and returned in acceptance order. Requests are
// only accepted while FIFO occupancy plus ops still in flight leaves room.
module fadd_result_collector #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input logic                   clk,
    input logic                   rst,
    fadd_result_collector_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INF_W = 3;
    localparam int CR_W  = CNT_W + INF_W;

    // Valid/tag pipeline alongside fadd
    logic [LATENCY-1:0] vld_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];

    // Result FIFO storage and control
    logic [31:0]        mem_d_q   [DEPTH];
    logic               mem_ovf_q [DEPTH];
    logic [TAG_W-1:0]   mem_tag_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_sticky_q, ovf_sticky_d;

    logic [INF_W-1:0]   inflight_w;
    logic               req_ready_w;
    logic               fire_w;
    logic               push_w;
    logic               pop_w;
    logic               resp_valid_w;

    // Operands follow the request inputs unconditionally; subtract flips t's sign.
    assign bus.fadd_s = bus.req_s;
    assign bus.fadd_t = {bus.req_t[31] ^ bus.req_sub, bus.req_t[30:0]};

    // Count ops currently travelling through fadd.
    always_comb begin
        inflight_w = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_w = inflight_w + INF_W'(vld_q[i]);
        end
    end

    // Credit uses registered state only, so resp_ready never reaches req_ready.
    assign req_ready_w  = !rst &&
                          ((CR_W'(count_q) + CR_W'(inflight_w)) < CR_W'(DEPTH));
    assign fire_w       = bus.req_valid && req_ready_w;
    assign push_w       = vld_q[LATENCY-1];
    assign resp_valid_w = (count_q != '0);
    assign pop_w        = resp_valid_w && bus.resp_ready;

    assign bus.req_ready     = req_ready_w;
    assign bus.resp_valid    = resp_valid_w;
    assign bus.resp_d        = mem_d_q[rd_ptr_q];
    assign bus.resp_overflow = mem_ovf_q[rd_ptr_q];
    assign bus.resp_tag      = mem_tag_q[rd_ptr_q];
    assign bus.ovf_sticky    = ovf_sticky_q;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_sticky_d = ovf_sticky_q;
        if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A new overflow result beats a simultaneous clear.
        if (push_w && bus.fadd_overflow) begin
            ovf_sticky_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    // Valid pipeline: cleared on reset so late fadd results are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= fire_w;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Tag pipeline: payload only, qualified by vld_q.
    always_ff @(posedge clk) begin
        tag_q[0] <= bus.req_tag;
        for (int i = 1; i < LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    // FIFO storage write: capture fadd's output for the op at the pipeline end.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_d_q[wr_ptr_q]   <= bus.fadd_d;
            mem_ovf_q[wr_ptr_q] <= bus.fadd_overflow;
            mem_tag_q[wr_ptr_q] <= tag_q[LATENCY-1];
        end
    end

    // FIFO control and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    // The credit rule makes a push into a full FIFO unreachable.
    push_while_full_a: assert property (@(posedge clk) disable iff (rst)
        !(push_w && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fadd_result_collector.sv
// Directed bench for fadd_result_collector with a behavioural fadd table,
// an expected-response queue fed by the request driver and a monitor that
// checks every returned result.
module tb_fadd_result_collector;
    localparam int LATENCY = 1;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int W       = 32 + 1 + TAG_W;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [W-1:0] exp_q[$];

    fadd_result_collector_if #(.TAG_W(TAG_W)) bus ();

    fadd_result_collector #(
        .LATENCY(LATENCY),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural fadd: hand-computed results for the vectors used here.
    function automatic logic [32:0] fadd_model(input logic [31:0] s, input logic [31:0] t);
        logic [32:0] r;
        r = {s ^ t, 1'b0};
        if (s == 32'h3F800000 && t == 32'h40000000) r = {32'h40400000, 1'b0}; // 1+2
        if (s == 32'h40400000 && t == 32'hBF800000) r = {32'h40000000, 1'b0}; // 3-1
        if (s == 32'h40000000 && t == 32'h40000000) r = {32'h40800000, 1'b0}; // 2+2
        if (s == 32'h40800000 && t == 32'hBF800000) r = {32'h40400000, 1'b0}; // 4-1
        if (s == 32'h3F800000 && t == 32'h3F800000) r = {32'h40000000, 1'b0}; // 1+1
        if (s == 32'h7F7FFFFF && t == 32'h7F7FFFFF) r = {32'h7F800000, 1'b1}; // max+max
        return r;
    endfunction

    logic [32:0] fpipe [LATENCY];
    always @(posedge clk) begin
        fpipe[0] <= fadd_model(bus.fadd_s, bus.fadd_t);
        for (int i = 1; i < LATENCY; i++) begin
            fpipe[i] <= fpipe[i-1];
        end
    end
    assign bus.fadd_d        = fpipe[LATENCY-1][32:1];
    assign bus.fadd_overflow = fpipe[LATENCY-1][0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare every accepted response against the queue head.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected actual=%0h required=none",
                         {bus.resp_d, bus.resp_overflow, bus.resp_tag});
            end else begin
                check("resp_data", 64'({bus.resp_d, bus.resp_overflow, bus.resp_tag}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    // Driver: offer one request until accepted, record its expected result.
    task automatic send(input logic [31:0] s, input logic [31:0] t, input logic sub,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp_t,
                        input logic [31:0] exp_d, input logic exp_ovf);
        bit accepted;
        accepted      = 0;
        bus.req_valid = 1'b1;
        bus.req_s     = s;
        bus.req_t     = t;
        bus.req_sub   = sub;
        bus.req_tag   = tag;
        for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                accepted = 1;
                check("fadd_t", 64'(bus.fadd_t), 64'(exp_t));
                exp_q.push_back({exp_d, exp_ovf, tag});
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept required=accept tag=%0d", tag);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int acc;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_s      = '0;
        bus.req_t      = '0;
        bus.req_sub    = 1'b0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        bus.ovf_clr    = 1'b0;

        // Reset
        @(negedge clk);
        check("rst_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_sticky", 64'(bus.ovf_sticky), 64'd0);
        @(posedge clk);
        #1;

        // Single add and its latency
        bus.resp_ready = 1'b1;
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd3, 32'h40000000, 32'h40400000, 1'b0);
        @(negedge clk);
        check("add_lat_early", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("add_lat_valid", 64'(bus.resp_valid), 64'd1);
        wait_drain();

        // Subtract
        send(32'h40400000, 32'h3F800000, 1'b1, 4'd7, 32'hBF800000, 32'h40000000, 1'b0);
        wait_drain();
        idle(2);

        // Backpressure and credit
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_s      = 32'h3F800000;
        bus.req_t      = 32'h40000000;
        bus.req_sub    = 1'b0;
        acc            = 0;
        bus.req_tag    = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                exp_q.push_back({32'h40400000, 1'b0, TAG_W'(acc)});
                acc++;
            end
            @(posedge clk);
            #1;
            bus.req_tag = TAG_W'(acc);
        end
        @(negedge clk);
        check("bp_accepts", 64'(acc), 64'(DEPTH));
        check("bp_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_same_cycle", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
        wait_drain();

        // Overflow and sticky flag
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd9, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
        wait_drain();
        @(negedge clk);
        check("ovf_sticky_set", 64'(bus.ovf_sticky), 64'd1);
        @(posedge clk);
        #1;
        bus.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_sticky_clr", 64'(bus.ovf_sticky), 64'd0);
        @(posedge clk);
        #1;
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd10, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
        bus.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_set_beats_clr", 64'(bus.ovf_sticky), 64'd1);
        wait_drain();
        bus.ovf_clr = 1'b1;
        idle(1);
        bus.ovf_clr = 1'b0;

        // Streaming back-to-back
        bus.req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.req_tag = TAG_W'(i + 1);
            case (i % 3)
                0: begin
                    bus.req_s = 32'h40000000; bus.req_t = 32'h40000000; bus.req_sub = 1'b0;
                end
                1: begin
                    bus.req_s = 32'h40800000; bus.req_t = 32'h3F800000; bus.req_sub = 1'b1;
                end
                default: begin
                    bus.req_s = 32'h3F800000; bus.req_t = 32'h3F800000; bus.req_sub = 1'b0;
                end
            endcase
            @(negedge clk);
            check("stream_ready", 64'(bus.req_ready), 64'd1);
            if (bus.req_ready) begin
                case (i % 3)
                    0:       exp_q.push_back({32'h40800000, 1'b0, TAG_W'(i + 1)});
                    1:       exp_q.push_back({32'h40400000, 1'b0, TAG_W'(i + 1)});
                    default: exp_q.push_back({32'h40000000, 1'b0, TAG_W'(i + 1)});
                endcase
            end
            if (i >= 2) begin
                check("stream_resp_valid", 64'(bus.resp_valid), 64'd1);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        wait_drain();

        // Reset with one result buffered and one op in flight
        bus.resp_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40000000, 32'h40400000, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0, 4'd6, 32'h40000000, 32'h40800000, 1'b0);
        rst = 1'b1;
        bus.req_valid = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
            check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
            @(posedge clk);
            #1;
        end

        // Normal operation resumes after reset
        send(32'h40400000, 32'h3F800000, 1'b1, 4'd12, 32'hBF800000, 32'h40000000, 1'b0);
        wait_drain();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
